// File: rtl/bht_controller.sv
// Branch history table controller: 2-bit saturating counters with a single access slot shared
// between fetch lookups and queued execute-stage updates, plus an init/clear sweep.
module bht_controller #(
    parameter int unsigned LOWER        = 5,
    parameter int unsigned QDEPTH       = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter logic [1:0]  INIT_STATE   = 2'b01
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      lookup_valid,
    input  logic [LOWER-1:0]          lookup_addr,
    output logic                      lookup_ready,
    output logic                      pred_valid,
    output logic                      pred_taken,
    input  logic                      upd_valid,
    input  logic [LOWER-1:0]          upd_addr,
    input  logic                      upd_taken,
    output logic                      upd_ready,
    input  logic                      clear,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int unsigned ENTRIES = 2 ** LOWER;
    localparam int unsigned PW      = $clog2(QDEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam int unsigned SW      = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [LOWER-1:0] sweep_q, sweep_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;

    logic [1:0]       bht_q [ENTRIES];
    logic [LOWER-1:0] fifo_addr_q [QDEPTH];
    logic             fifo_taken_q [QDEPTH];

    logic             run, full, starved, non_empty, forced_drain;
    logic             drain, lookup_fire, push;
    logic             tbl_we;
    logic [LOWER-1:0] tbl_waddr;
    logic [1:0]       tbl_wdata;
    logic [LOWER-1:0] head_addr;
    logic             head_taken;
    logic [1:0]       head_cnt, head_sat;

    assign run          = (state_q == StRun);
    assign full         = (count_q == CW'(QDEPTH));
    assign starved      = (starve_q == SW'(STARVE_LIMIT));
    assign non_empty    = (count_q != '0);
    assign forced_drain = full | starved;

    // Ready signals come from registered state only, so they never depend on same-cycle inputs.
    assign lookup_ready = run & ~forced_drain;
    assign upd_ready    = run & ~full;
    assign busy         = (state_q == StInit);
    assign q_count      = count_q;
    assign pred_valid   = pred_valid_q;
    assign pred_taken   = pred_taken_q;

    assign drain        = run & non_empty & (forced_drain | ~lookup_valid);
    assign lookup_fire  = lookup_valid & lookup_ready;
    assign push         = upd_valid & upd_ready & ~clear;

    assign head_addr    = fifo_addr_q[rd_ptr_q];
    assign head_taken   = fifo_taken_q[rd_ptr_q];
    assign head_cnt     = bht_q[head_addr];

    always_comb begin
        head_sat = head_cnt;
        if (head_taken) begin
            if (head_cnt != 2'b11) head_sat = head_cnt + 2'd1;
        end else begin
            if (head_cnt != 2'b00) head_sat = head_cnt - 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        starve_d     = starve_q;
        tbl_we       = 1'b0;
        tbl_waddr    = sweep_q;
        tbl_wdata    = INIT_STATE;
        pred_valid_d = lookup_fire;
        pred_taken_d = lookup_fire ? bht_q[lookup_addr][1] : pred_taken_q;

        unique case (state_q)
            StInit: begin
                tbl_we = 1'b1;
                if (clear) begin
                    sweep_d = '0;
                end else if (sweep_q == {LOWER{1'b1}}) begin
                    sweep_d = '0;
                    state_d = StRun;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            StRun: begin
                if (drain && !clear) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = head_addr;
                    tbl_wdata = head_sat;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                end
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + CW'(push) - CW'(drain);
                // A non-empty queue that did not drain this cycle lost the slot to a lookup.
                starve_d = (non_empty && !drain) ? starve_q + 1'b1 : '0;
                if (clear) begin
                    state_d  = StInit;
                    sweep_d  = '0;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    starve_d = '0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= StInit;
            sweep_q      <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            starve_q     <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            starve_q     <= starve_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    // Storage arrays need no reset: the sweep initialises the table and pointers guard the FIFO.
    always_ff @(posedge clk) begin
        if (tbl_we) bht_q[tbl_waddr] <= tbl_wdata;
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= upd_addr;
            fifo_taken_q[wr_ptr_q] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_bht_controller.sv
// Directed bench for bht_controller; predictions are checked by a scoreboard monitor.
module tb_bht_controller;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       lookup_valid = 1'b0;
    logic [4:0] lookup_addr = '0;
    logic       lookup_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       upd_valid = 1'b0;
    logic [4:0] upd_addr = '0;
    logic       upd_taken = 1'b0;
    logic       upd_ready;
    logic       clear = 1'b0;
    logic       busy;
    logic [2:0] q_count;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    bht_controller #(
        .LOWER(5),
        .QDEPTH(4),
        .STARVE_LIMIT(8),
        .INIT_STATE(2'b01)
    ) dut (
        .clk(clk),
        .arst(arst),
        .lookup_valid(lookup_valid),
        .lookup_addr(lookup_addr),
        .lookup_ready(lookup_ready),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .upd_valid(upd_valid),
        .upd_addr(upd_addr),
        .upd_taken(upd_taken),
        .upd_ready(upd_ready),
        .clear(clear),
        .busy(busy),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented prediction is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!arst && pred_valid) begin
            if (exp_q.size() == 0) begin
                chk("pred_unexpected", 32'(pred_taken), 32'hFFFF_FFFF);
            end else begin
                chk("pred_taken", 32'(pred_taken), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic lookup(input logic [4:0] a, input bit exp);
        lookup_valid = 1'b1;
        lookup_addr  = a;
        chk("lookup_ready", 32'(lookup_ready), 1);
        exp_q.push_back(exp);
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [4:0] a, input logic t);
        int n = 0;
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_taken = t;
        while (!upd_ready && n < 100) begin
            step();
            n++;
        end
        if (n == 100) chk("upd_accept_timeout", 32'(upd_ready), 1);
        step();
        upd_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q_count != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(q_count), 0);
    endtask

    task automatic count_busy(input int exp);
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("sweep_len", n, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [4:0] t4_addr[4]  = '{5'd10, 5'd10, 5'd12, 5'd13};
        logic       t4_taken[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

        // Reset values and sweep length
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 1);
        chk("rst_lookup_ready", 32'(lookup_ready), 0);
        chk("rst_upd_ready", 32'(upd_ready), 0);
        chk("rst_q_count", 32'(q_count), 0);
        chk("rst_pred_valid", 32'(pred_valid), 0);
        chk("rst_pred_taken", 32'(pred_taken), 0);
        arst = 1'b0;
        count_busy(32);
        chk("run_lookup_ready", 32'(lookup_ready), 1);
        chk("run_upd_ready", 32'(upd_ready), 1);
        lookup(5'd7, 1'b0);

        // Saturation up and down on entry 3
        update(5'd3, 1'b1);
        wait_empty();
        lookup(5'd3, 1'b1);
        step();
        chk("hold_pred_valid", 32'(pred_valid), 0);
        chk("hold_pred_taken", 32'(pred_taken), 1);
        repeat (3) update(5'd3, 1'b1);
        wait_empty();
        update(5'd3, 1'b0);
        wait_empty();
        lookup(5'd3, 1'b1);
        repeat (3) update(5'd3, 1'b0);
        wait_empty();
        lookup(5'd3, 1'b0);

        // Starvation limit under continuous lookups
        lookup_valid = 1'b1;
        lookup_addr  = 5'd0;
        upd_valid    = 1'b1;
        upd_addr     = 5'd20;
        upd_taken    = 1'b1;
        chk("t3_upd_ready", 32'(upd_ready), 1);
        exp_q.push_back(1'b0);
        step();
        upd_valid = 1'b0;
        n = 0;
        while (lookup_ready && n < 50) begin
            exp_q.push_back(1'b0);
            n++;
            step();
        end
        chk("t3_lookup_wins", n, 8);
        chk("t3_lookup_ready_low", 32'(lookup_ready), 0);
        chk("t3_q_count_before", 32'(q_count), 1);
        step();
        chk("t3_q_count_after", 32'(q_count), 0);
        chk("t3_lookup_ready_back", 32'(lookup_ready), 1);
        lookup_valid = 1'b0;
        lookup(5'd20, 1'b1);

        // Fill the queue during lookups; full blocks a same-cycle pass-through update
        lookup_valid = 1'b1;
        lookup_addr  = 5'd0;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_addr  = t4_addr[i];
            upd_taken = t4_taken[i];
            chk("t4_upd_ready", 32'(upd_ready), 1);
            exp_q.push_back(1'b0);
            step();
        end
        upd_addr  = 5'd14;
        upd_taken = 1'b1;
        chk("t4_full_count", 32'(q_count), 4);
        chk("t4_full_upd_ready", 32'(upd_ready), 0);
        chk("t4_full_lookup_ready", 32'(lookup_ready), 0);
        step();
        upd_valid    = 1'b0;
        lookup_valid = 1'b0;
        chk("t4_after_drain_count", 32'(q_count), 3);
        chk("t4_after_drain_upd_ready", 32'(upd_ready), 1);
        chk("t4_after_drain_lookup_ready", 32'(lookup_ready), 1);
        n = 0;
        while (q_count != 2 && n < 20) begin
            step();
            n++;
        end
        chk("t4_two_drained", 32'(q_count), 2);
        lookup(5'd10, 1'b1);
        wait_empty();
        update(5'd10, 1'b0);
        wait_empty();
        lookup(5'd10, 1'b1);
        lookup(5'd12, 1'b0);
        lookup(5'd13, 1'b1);
        lookup(5'd14, 1'b0);

        // Clear with three queued updates and a same-cycle lookup
        lookup_valid = 1'b1;
        lookup_addr  = 5'd5;
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1;
            upd_addr  = 5'd5;
            upd_taken = 1'b1;
            exp_q.push_back(1'b0);
            step();
        end
        chk("t5_q_count", 32'(q_count), 3);
        clear = 1'b1;
        chk("t5_clear_lookup_ready", 32'(lookup_ready), 1);
        exp_q.push_back(1'b0);
        step();
        clear        = 1'b0;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        chk("t5_busy", 32'(busy), 1);
        chk("t5_q_count_cleared", 32'(q_count), 0);
        chk("t5_lookup_ready", 32'(lookup_ready), 0);
        chk("t5_upd_ready", 32'(upd_ready), 0);
        count_busy(32);
        lookup(5'd5, 1'b0);
        lookup(5'd20, 1'b0);
        lookup(5'd10, 1'b0);
        lookup(5'd13, 1'b0);
        lookup(5'd0, 1'b0);

        // Asynchronous reset in the middle of a clear sweep
        update(5'd30, 1'b1);
        wait_empty();
        lookup(5'd30, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (15) step();
        arst = 1'b1;
        #2;
        chk("t6_arst_busy", 32'(busy), 1);
        chk("t6_arst_q_count", 32'(q_count), 0);
        chk("t6_arst_lookup_ready", 32'(lookup_ready), 0);
        chk("t6_arst_pred_valid", 32'(pred_valid), 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        count_busy(32);
        lookup(5'd30, 1'b0);

        step();
        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
